// File: rtl/hazard_ctrl.sv
// hazard_ctrl
// Pipeline hazard controller for the five-stage RV32I core. Keeps shadow
// copies of the X, M and W stage instructions and compares them against the
// decode instruction to produce operand bypass selects, decode register-file
// write-through selects, the load-use stall and the redirect flush. Saturating
// stall/flush event counters are kept for performance debug.
//
// Ports:
//   clk            pipeline clock, rising edge
//   reset          asynchronous active-high reset
//   inst_d         instruction in decode
//   branch_taken_x execute-stage PCSel (taken branch / JAL / JALR in X)
//   rs1_bypass     X rs1 source: 00 regfile, 01 MX (alu_m), 10 WX (writeback)
//   rs2_bypass     X rs2 source, same encoding
//   wd_rs1         decode rs1 read takes writeback data
//   wd_rs2         decode rs2 read takes writeback data
//   stall_fd       hold PC and F/D register this cycle
//   flush_fd       replace F/D contents with NOP at the next edge
//   stall_cnt      saturating count of stall cycles
//   flush_cnt      saturating count of flush cycles
module hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      inst_d,
  input  logic             branch_taken_x,
  output logic [1:0]       rs1_bypass,
  output logic [1:0]       rs2_bypass,
  output logic             wd_rs1,
  output logic             wd_rs2,
  output logic             stall_fd,
  output logic             flush_fd,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [31:0] NOP       = 32'h0000_0013;
  localparam logic [6:0]  OP_LUI    = 7'b0110111;
  localparam logic [6:0]  OP_AUIPC  = 7'b0010111;
  localparam logic [6:0]  OP_JAL    = 7'b1101111;
  localparam logic [6:0]  OP_JALR   = 7'b1100111;
  localparam logic [6:0]  OP_BCC    = 7'b1100011;
  localparam logic [6:0]  OP_LCC    = 7'b0000011;
  localparam logic [6:0]  OP_SCC    = 7'b0100011;
  localparam logic [6:0]  OP_MCC    = 7'b0010011;
  localparam logic [6:0]  OP_RCC    = 7'b0110011;

  logic [31:0] inst_x_q;
  logic [31:0] inst_m_q;
  logic [31:0] inst_w_q;

  // A write to x0 is treated as no write so it never creates a hazard.
  function automatic logic writes_rd(input logic [31:0] inst);
    logic w;
    case (inst[6:0])
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LCC, OP_MCC, OP_RCC: w = 1'b1;
      default: w = 1'b0;
    endcase
    return w && (inst[11:7] != 5'd0);
  endfunction

  function automatic logic reads_rs1(input logic [31:0] inst);
    logic r;
    case (inst[6:0])
      OP_JALR, OP_BCC, OP_LCC, OP_SCC, OP_MCC, OP_RCC: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic reads_rs2(input logic [31:0] inst);
    logic r;
    case (inst[6:0])
      OP_BCC, OP_SCC, OP_RCC: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic is_load(input logic [31:0] inst);
    return inst[6:0] == OP_LCC;
  endfunction

  // Producer's rd (already known non-zero) equals consumer's rs1/rs2.
  function automatic logic match_rs1(input logic [31:0] prod, input logic [31:0] cons);
    return writes_rd(prod) && reads_rs1(cons) && (prod[11:7] == cons[19:15]);
  endfunction

  function automatic logic match_rs2(input logic [31:0] prod, input logic [31:0] cons);
    return writes_rd(prod) && reads_rs2(cons) && (prod[11:7] == cons[24:20]);
  endfunction

  // Bypass selects depend only on shadow registers, never on branch_taken_x,
  // since execute derives PCSel from the bypassed operands. A load in M that
  // matches X is unreachable (the stall prevents it); it yields 00 rather
  // than falling through to a stale W value.
  always_comb begin
    rs1_bypass = 2'b00;
    rs2_bypass = 2'b00;
    if (match_rs1(inst_m_q, inst_x_q)) begin
      rs1_bypass = is_load(inst_m_q) ? 2'b00 : 2'b01;
    end else if (match_rs1(inst_w_q, inst_x_q)) begin
      rs1_bypass = 2'b10;
    end
    if (match_rs2(inst_m_q, inst_x_q)) begin
      rs2_bypass = is_load(inst_m_q) ? 2'b00 : 2'b01;
    end else if (match_rs2(inst_w_q, inst_x_q)) begin
      rs2_bypass = 2'b10;
    end
  end

  // Decode write-through, load-use stall and flush. The flush wins over the
  // stall; reset masks the flush so branch_taken_x is ignored while held.
  always_comb begin
    wd_rs1   = match_rs1(inst_w_q, inst_d);
    wd_rs2   = match_rs2(inst_w_q, inst_d);
    flush_fd = branch_taken_x && !reset;
    stall_fd = !branch_taken_x && is_load(inst_x_q) &&
               (match_rs1(inst_x_q, inst_d) || match_rs2(inst_x_q, inst_d));
  end

  // Shadow pipeline: a bubble enters X on stall or flush; the back end
  // never stalls so M and W always advance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inst_x_q <= NOP;
      inst_m_q <= NOP;
      inst_w_q <= NOP;
    end else begin
      inst_x_q <= (flush_fd || stall_fd) ? NOP : inst_d;
      inst_m_q <= inst_x_q;
      inst_w_q <= inst_m_q;
    end
  end

  // Saturating event counters; they hold at all ones instead of wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_fd && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (flush_fd && (flush_cnt != {CNT_W{1'b1}})) begin
        flush_cnt <= flush_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl
// Directed testbench for hazard_ctrl with hand-computed expected values.
// Counters are built 4 bits wide so saturation is reachable quickly.
module tb_hazard_ctrl;

  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [31:0] ADD5    = 32'h002082B3; // add x5,x1,x2
  localparam logic [31:0] ADD6    = 32'h00328333; // add x6,x5,x3
  localparam logic [31:0] ADD7    = 32'h005183B3; // add x7,x3,x5
  localparam logic [31:0] ADDI0   = 32'h00100013; // addi x0,x0,1
  localparam logic [31:0] ADD6Z   = 32'h00000333; // add x6,x0,x0
  localparam logic [31:0] LW5     = 32'h0000A283; // lw x5,0(x1)

  logic        clk;
  logic        reset;
  logic [31:0] inst_d;
  logic        branch_taken_x;
  logic [1:0]  rs1_bypass;
  logic [1:0]  rs2_bypass;
  logic        wd_rs1;
  logic        wd_rs2;
  logic        stall_fd;
  logic        flush_fd;
  logic [3:0]  stall_cnt;
  logic [3:0]  flush_cnt;

  int checksTotal;
  int checksPassed;

  hazard_ctrl #(.CNT_W(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .inst_d         (inst_d),
    .branch_taken_x (branch_taken_x),
    .rs1_bypass     (rs1_bypass),
    .rs2_bypass     (rs2_bypass),
    .wd_rs1         (wd_rs1),
    .wd_rs2         (wd_rs2),
    .stall_fd       (stall_fd),
    .flush_fd       (flush_fd),
    .stall_cnt      (stall_cnt),
    .flush_cnt      (flush_cnt)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle of inputs after the falling edge, then settle.
  task automatic applyStimulus(input logic [31:0] inst, input logic bt);
    @(negedge clk);
    inst_d = inst;
    branch_taken_x = bt;
    #1;
  endtask

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checksTotal++;
    if (obs !== exp) begin
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      checksPassed++;
    end
  endtask

  // Pulse reset for one cycle with idle inputs.
  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    inst_d = NOP;
    branch_taken_x = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Directed scenarios.
  initial begin
    checksTotal = 0;
    checksPassed = 0;
    reset = 1'b1;
    inst_d = LW5;
    branch_taken_x = 1'b1;
    #2;
    checkOutput("rst_flush", {31'd0, flush_fd}, 32'd0);
    checkOutput("rst_stall", {31'd0, stall_fd}, 32'd0);
    checkOutput("rst_byp", {28'd0, rs1_bypass, rs2_bypass}, 32'd0);
    checkOutput("rst_wd", {30'd0, wd_rs1, wd_rs2}, 32'd0);
    checkOutput("rst_cnt", {24'd0, stall_cnt, flush_cnt}, 32'd0);
    repeat (2) @(posedge clk);
    checkOutput("rst_cnt_held", {24'd0, stall_cnt, flush_cnt}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    branch_taken_x = 1'b0;
    #1;
    checkOutput("post_rst_all",
                {22'd0, rs1_bypass, rs2_bypass, wd_rs1, wd_rs2, stall_fd, flush_fd, stall_cnt},
                32'd0);
    checkOutput("post_rst_fcnt", {28'd0, flush_cnt}, 32'd0);

    // ALU forwarding M->X on rs1.
    doReset();
    applyStimulus(ADD5, 1'b0);
    applyStimulus(ADD6, 1'b0);
    applyStimulus(NOP, 1'b0);
    checkOutput("mx_rs1", {30'd0, rs1_bypass}, 32'd1);
    checkOutput("mx_rs2_none", {30'd0, rs2_bypass}, 32'd0);

    // W->X on rs1 with one bubble.
    doReset();
    applyStimulus(ADD5, 1'b0);
    applyStimulus(NOP, 1'b0);
    applyStimulus(ADD6, 1'b0);
    applyStimulus(NOP, 1'b0);
    checkOutput("wx_rs1", {30'd0, rs1_bypass}, 32'd2);

    // M->X on rs2, plus M beating W when both produce x5.
    doReset();
    applyStimulus(ADD5, 1'b0);
    applyStimulus(ADD5, 1'b0);
    applyStimulus(ADD7, 1'b0);
    applyStimulus(NOP, 1'b0);
    checkOutput("mx_rs2_prio", {30'd0, rs2_bypass}, 32'd1);
    checkOutput("mx_rs2_rs1", {30'd0, rs1_bypass}, 32'd0);

    // Decode write-through: producer in W, consumer in D.
    doReset();
    applyStimulus(ADD5, 1'b0);
    applyStimulus(NOP, 1'b0);
    applyStimulus(NOP, 1'b0);
    applyStimulus(ADD6, 1'b0);
    checkOutput("wd_rs1", {31'd0, wd_rs1}, 32'd1);
    checkOutput("wd_rs2", {31'd0, wd_rs2}, 32'd0);

    // x0 suppression.
    doReset();
    applyStimulus(ADDI0, 1'b0);
    applyStimulus(ADD6Z, 1'b0);
    applyStimulus(NOP, 1'b0);
    checkOutput("x0_byp", {28'd0, rs1_bypass, rs2_bypass}, 32'd0);
    doReset();
    applyStimulus(ADDI0, 1'b0);
    applyStimulus(NOP, 1'b0);
    applyStimulus(NOP, 1'b0);
    applyStimulus(ADD6Z, 1'b0);
    checkOutput("x0_wd", {30'd0, wd_rs1, wd_rs2}, 32'd0);

    // Load-use: one stall cycle, bubble in X, then WX.
    doReset();
    applyStimulus(LW5, 1'b0);
    applyStimulus(ADD6, 1'b0);
    checkOutput("lu_stall", {31'd0, stall_fd}, 32'd1);
    applyStimulus(ADD6, 1'b0);
    checkOutput("lu_stall_once", {31'd0, stall_fd}, 32'd0);
    checkOutput("lu_x_nop", dut.inst_x_q, NOP);
    checkOutput("lu_scnt1", {28'd0, stall_cnt}, 32'd1);
    applyStimulus(NOP, 1'b0);
    checkOutput("lu_wx", {30'd0, rs1_bypass}, 32'd2);
    checkOutput("lu_scnt", {28'd0, stall_cnt}, 32'd1);

    // Flush beats stall.
    doReset();
    applyStimulus(LW5, 1'b0);
    applyStimulus(ADD6, 1'b1);
    checkOutput("fb_flush", {31'd0, flush_fd}, 32'd1);
    checkOutput("fb_stall", {31'd0, stall_fd}, 32'd0);
    applyStimulus(NOP, 1'b0);
    checkOutput("fb_x_nop", dut.inst_x_q, NOP);
    checkOutput("fb_fcnt", {28'd0, flush_cnt}, 32'd1);
    checkOutput("fb_scnt", {28'd0, stall_cnt}, 32'd0);

    // Reset asserted mid-stall clears state immediately.
    doReset();
    applyStimulus(LW5, 1'b0);
    applyStimulus(ADD6, 1'b0);
    reset = 1'b1;
    #1;
    checkOutput("mid_rst_stall", {31'd0, stall_fd}, 32'd0);
    checkOutput("mid_rst_x", dut.inst_x_q, NOP);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("mid_rst_after", {31'd0, stall_fd}, 32'd0);

    // Flush counter saturation at 15.
    doReset();
    for (int i = 0; i < 10; i++) applyStimulus(NOP, 1'b1);
    checkOutput("sat_mid", {28'd0, flush_cnt}, 32'd9);
    for (int i = 0; i < 10; i++) applyStimulus(NOP, 1'b1);
    applyStimulus(NOP, 1'b0);
    checkOutput("sat_end", {28'd0, flush_cnt}, 32'd15);
    checkOutput("sat_scnt", {28'd0, stall_cnt}, 32'd0);

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage RV32I core. It keeps shadow copies of the instructions in the X, M and W stages and compares them against the decode-stage instruction. From that it drives the execute-stage operand bypass selects, the decode register-file write-through selects, the load-use stall and the taken-branch/JALR flush. It also keeps saturating stall and flush event counters for performance debug.

## Interface
Parameters:
- CNT_W, 16, width of the stall and flush event counters.

Ports:
- clk  input  1  pipeline clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- inst_d  input  32  instruction currently in the decode stage.
- branch_taken_x  input  1  execute-stage PCSel; high when the instruction in X redirects the PC (taken branch, JAL, JALR).
- rs1_bypass  output  2  X-stage rs1 source: 2'b00 register file, 2'b01 MX (alu_m), 2'b10 WX (writeback).
- rs2_bypass  output  2  X-stage rs2 source, same encoding.
- wd_rs1  output  1  decode rs1 read takes the writeback data instead of the register file.
- wd_rs2  output  1  decode rs2 read takes the writeback data instead of the register file.
- stall_fd  output  1  hold PC and the F/D register this cycle.
- flush_fd  output  1  replace the F/D register contents with NOP (0x00000013) at the next edge.
- stall_cnt  output  CNT_W  number of stall cycles, saturating.
- flush_cnt  output  CNT_W  number of flush cycles, saturating.

## Operation
Decode classes by opcode [6:0]:
- Writes rd: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, LCC 0000011, MCC 0010011, RCC 0110011.
- Reads rs1: JALR, BCC 1100011, LCC, SCC 0100011, MCC, RCC.
- Reads rs2: BCC, SCC, RCC.
- Any other opcode neither reads nor writes.
- A write with rd = x0 counts as no write. A comparison matches only when the producer writes, the consumer reads that source, and the register indices are equal and non-zero.

Shadow registers inst_x_q, inst_m_q and inst_w_q:
- Reset value of all three: NOP 0x00000013.
- inst_x_q <= NOP if flush_fd or stall_fd, else inst_d.
- inst_m_q <= inst_x_q and inst_w_q <= inst_m_q unconditionally; the back end never stalls.

Bypass selects (combinational, for inst_x_q):
- Select MX if inst_m_q matches and is not LCC.
- Else select WX if inst_w_q matches.
- Else select 00.
- M beats W when both match.
- An LCC in M matching X cannot occur, because the stall rule prevents it. If it does occur anyway, output 00.

Decode write-through:
- wd_rs1 / wd_rs2 = inst_w_q matches the corresponding source of inst_d.

Load-use stall:
- stall_fd = inst_x_q is LCC and matches rs1 or rs2 of inst_d, and branch_taken_x = 0.
- The stall lasts exactly one cycle. Next cycle the load is in M and the consumer is still in D, so no further stall is raised. The consumer then enters X while the load is in W and receives WX.

Flush:
- flush_fd = branch_taken_x.
- The flush overrides the stall: the stall is forced to 0 and inst_x_q takes NOP.

Counters:
- stall_cnt increments on each edge with stall_fd = 1; flush_cnt on each edge with flush_fd = 1.
- Both saturate at all ones and do not wrap.

## Timing
- All outputs are combinational from the shadow registers, inst_d and branch_taken_x. There is no output register, so the latency from an input change to an output is 0 cycles.
- The execute muxes must capture on the same edge that advances the shadows.
- There is no combinational path from branch_taken_x to rs1_bypass/rs2_bypass. Execute computes PCSel from bypassed operands, so such a path would form a loop.
- During reset, the shadows hold NOP and all outputs are 0: bypass selects 00, wd_* 0, stall_fd 0, flush_fd 0 (branch_taken_x is ignored), counters 0.
- Reset asserted mid-stall or mid-flush clears the state immediately; the first instruction after release sees no hazard.
- Simultaneous flush and stall conditions: flush_fd = 1, stall_fd = 0, flush_cnt increments and stall_cnt does not.
- A flush inserts exactly one NOP into X and one into D; there is no multi-cycle flush state.

## Test plan
- Reset: assert reset with branch_taken_x = 1 and inst_d = 0x0000A283, then release. Required: every output is 0 during reset and on the first cycle after release.
- ALU forwarding: issue 0x002082B3 (add x5,x1,x2), then 0x00328333 (add x6,x5,x3). Required: rs1_bypass = 01 and rs2_bypass = 00 when the consumer is in X. With one NOP between the two instructions, rs1_bypass = 10.
- x0 suppression: issue 0x00100013 (addi x0,x0,1), then 0x00000333 (add x6,x0,x0). Required: both bypass selects 00 and wd_rs1 = 0.
- Load-use: issue 0x0000A283 (lw x5,0(x1)), then 0x00328333. Required: stall_fd = 1 for exactly one cycle and inst_x_q = NOP the next cycle. When the consumer reaches X, rs1_bypass = 10. Finally stall_cnt = 1.
- Flush beats stall: load-use condition present with branch_taken_x = 1 on the same cycle. Required: flush_fd = 1, stall_fd = 0, next inst_x_q = NOP, flush_cnt = 1, stall_cnt = 0.
- Saturation and write-through: with CNT_W = 4, hold branch_taken_x = 1 for 20 cycles. Required: flush_cnt stops at 15. Separately, with 0x002082B3 in W and D reading x5, wd_rs1 = 1.
